hazard_unit_mc: RTL

Parametrised hazard and stall controller for the 5-stage pipelined core; it is the companion block to the pipeline controller.
- Generates per-operand forwarding selects for N source operands (3 by default, covering MLA Ra).
- Generates load-use stalls, PC-write-pending stalls and early-branch flushes.
- Adds a multi-cycle Execute sequencer that holds F/D/E for a configurable multiply latency and injects bubbles into Memory.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/hazard_unit_mc_if.sv | 49 ++++
 rtl/mc_sequencer.sv | 77 +++++++
 rtl/hazard_unit_mc.sv | 75 +++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline hazard logic: forwarding select codes,
// multi-cycle sequencer state encoding and a count-width helper.
package pipe_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    // Width of the sequencer down-counter; at least one bit so the
    // register exists even when the sequencer is never entered.
    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Bundle of pipeline-status inputs and stall/flush/forward outputs that
// connects the hazard unit to the pipeline datapath/controller.
interface hazard_unit_mc_if #(
    parameter int AW      = 4,
    parameter int NUM_SRC = 3
);
    logic [NUM_SRC*AW-1:0] RAD;
    logic [NUM_SRC*AW-1:0] RAE;
    logic [AW-1:0]         WA3E;
    logic [AW-1:0]         WA3M;
    logic [AW-1:0]         WA3W;
    logic                  RegWriteE;
    logic                  RegWriteM;
    logic                  RegWriteW;
    logic                  MemtoRegE;
    logic                  PCSrcD;
    logic                  PCSrcE;
    logic                  PCSrcM;
    logic                  PCSrcW;
    logic                  BranchTakenD;
    logic                  MulStartE;
    logic [2*NUM_SRC-1:0]  ForwardE;
    logic                  StallF;
    logic                  StallD;
    logic                  StallE;
    logic                  FlushD;
    logic                  FlushE;
    logic                  BubbleM;
    logic                  MulBusy;
    logic                  MulDoneE;

    // Pipeline side: supplies stage status, consumes hazard controls.
    modport master (
        output RAD, RAE, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD, MulStartE,
        input  ForwardE, StallF, StallD, StallE, FlushD, FlushE,
        input  BubbleM, MulBusy, MulDoneE
    );

    // Hazard unit side.
    modport slave (
        input  RAD, RAE, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenD, MulStartE,
        output ForwardE, StallF, StallD, StallE, FlushD, FlushE,
        output BubbleM, MulBusy, MulDoneE
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle Execute sequencer: keeps a multi-cycle op in Execute for
// MUL_LAT cycles by stalling the front of the pipe, then releases it.
module mc_sequencer
    import pipe_pkg::*;
#(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic MulStartE,
    input  logic PCSrcW,
    output logic MulStall,
    output logic MulBusy,
    output logic MulDoneE
);

    localparam int              CW       = cnt_width(MUL_LAT);
    localparam logic            MULTI    = (MUL_LAT > 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          start_op;
    logic          count_zero;

    assign start_op   = (state == IDLE) && MulStartE && MULTI;
    assign count_zero = (count == '0);

    // Next-state logic; a retiring PC write aborts the op in flight and
    // also keeps a new op from being accepted, since E is being flushed.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (PCSrcW) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_op) begin
                        state_nxt = BUSY;
                        count_nxt = CNT_INIT;
                    end
                end
                BUSY: begin
                    if (!count_zero) begin
                        count_nxt = count - CW'(1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    // State and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    assign MulStall = !PCSrcW && (start_op || ((state == BUSY) && !count_zero));
    assign MulBusy  = (state == BUSY);
    assign MulDoneE = MULTI ? ((state == BUSY) && count_zero) : MulStartE;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard and stall controller for the 5-stage core: operand forwarding,
// load-use and PC-write stalls, branch flushes and multi-cycle hold.
module hazard_unit_mc
    import pipe_pkg::*;
#(
    parameter int AW      = 4,
    parameter int NUM_SRC = 3,
    parameter int MUL_LAT = 3,
    parameter int PC_REG  = 15
) (
    input  logic        clk,
    input  logic        reset,
    hazard_unit_mc_if.slave hz
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG);

    logic ldr_stall;
    logic rad_hit;
    logic pc_wr_pending;
    logic mul_stall;
    logic mul_busy;
    logic mul_done;
    logic [2*NUM_SRC-1:0] fwd;

    // Per-operand forwarding select; Memory result wins over Writeback,
    // and the PC is never forwarded.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
        logic [AW-1:0] ra_e;
        logic          hit_m;
        logic          hit_w;
        assign ra_e  = hz.RAE[gi*AW +: AW];
        assign hit_m = hz.RegWriteM && (hz.WA3M == ra_e) && (ra_e != PC_ADDR);
        assign hit_w = hz.RegWriteW && (hz.WA3W == ra_e) && (ra_e != PC_ADDR);
        assign fwd[2*gi +: 2] = hit_m ? FWD_M : (hit_w ? FWD_W : FWD_RF);
    end

    // Any Decode source that matches the destination of a load in Execute.
    always_comb begin
        rad_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (hz.RAD[i*AW +: AW] == hz.WA3E) begin
                rad_hit = 1'b1;
            end
        end
    end

    assign ldr_stall     = hz.MemtoRegE && hz.RegWriteE && rad_hit;
    assign pc_wr_pending = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;

    mc_sequencer #(
        .MUL_LAT (MUL_LAT)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .MulStartE (hz.MulStartE),
        .PCSrcW    (hz.PCSrcW),
        .MulStall  (mul_stall),
        .MulBusy   (mul_busy),
        .MulDoneE  (mul_done)
    );

    // A multi-cycle hold dominates: D is frozen so any flush it would
    // cause re-asserts once the sequencer lets go.
    assign hz.ForwardE = fwd;
    assign hz.StallF   = mul_stall || ldr_stall || pc_wr_pending;
    assign hz.StallD   = mul_stall || ldr_stall;
    assign hz.StallE   = mul_stall;
    assign hz.BubbleM  = mul_stall;
    assign hz.FlushE   = !mul_stall && (ldr_stall || hz.BranchTakenD);
    assign hz.FlushD   = !mul_stall && (pc_wr_pending || hz.PCSrcW || hz.BranchTakenD);
    assign hz.MulBusy  = mul_busy;
    assign hz.MulDoneE = mul_done;

endmodule
